// File: rtl/frame_check.sv
// Receive-side frame checker: aligns to the K28.5K28.5 comma word and verifies the fixed
// 4-word test frame, reporting lock state, good-frame count and word-error count.
module frame_check #(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned LOSS_FRAMES = 4,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned FRM_W       = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             rx_ready,
  input  logic [15:0]      rx_data,
  input  logic [1:0]       rx_is_k,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             comma_seen,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned MaxFrames = (LOCK_FRAMES > LOSS_FRAMES) ? LOCK_FRAMES : LOSS_FRAMES;
  localparam int unsigned CNT_W     = $clog2(MaxFrames + 1);
  localparam logic [CNT_W-1:0] LockCnt = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] LossCnt = CNT_W'(LOSS_FRAMES);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e           r_state, w_state_d;
  logic [1:0]       r_idx, w_idx_d;
  logic [CNT_W-1:0] r_good, w_good_d;
  logic [CNT_W-1:0] r_bad, w_bad_d;
  logic             r_frm_bad, w_frm_bad_d;
  logic             r_comma, w_comma_d;
  logic [FRM_W-1:0] r_frame_cnt, w_frame_cnt_d;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_d;

  logic [15:0] w_exp;
  logic        w_match;
  logic        w_comma;

  always_comb begin
    w_exp = 16'h0000;
    unique case (r_idx)
      2'd0: w_exp = 16'h5854;
      2'd1: w_exp = 16'h4034;
      2'd2: w_exp = 16'h23A7;
      2'd3: w_exp = 16'hBCBC;
      default: w_exp = 16'h0000;
    endcase
  end

  assign w_comma = (rx_data == 16'hBCBC) && (rx_is_k == 2'b11);
  assign w_match = (rx_data == w_exp) && (rx_is_k == ((r_idx == 2'd3) ? 2'b11 : 2'b00));

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_good_d      = r_good;
    w_bad_d       = r_bad;
    w_frm_bad_d   = r_frm_bad;
    w_frame_cnt_d = r_frame_cnt;
    w_err_cnt_d   = r_err_cnt;
    w_comma_d     = w_comma;

    if (!rx_ready) begin
      w_state_d   = StHunt;
      w_idx_d     = 2'd0;
      w_good_d    = '0;
      w_bad_d     = '0;
      w_frm_bad_d = 1'b0;
    end else begin
      unique case (r_state)
        StHunt: begin
          if (w_comma) begin
            w_state_d = StVerify;
            w_idx_d   = 2'd0;
            w_good_d  = '0;
          end
        end
        StVerify: begin
          w_idx_d = r_idx + 2'd1;
          if (!w_match) begin
            w_state_d = StHunt;
            w_idx_d   = 2'd0;
            w_good_d  = '0;
          end else if (r_idx == 2'd3) begin
            if (r_good + CNT_W'(1) == LockCnt) begin
              w_state_d   = StLocked;
              w_good_d    = '0;
              w_bad_d     = '0;
              w_frm_bad_d = 1'b0;
            end else begin
              w_good_d = r_good + CNT_W'(1);
            end
          end
        end
        StLocked: begin
          w_idx_d = r_idx + 2'd1;
          if (!w_match && !(&r_err_cnt)) w_err_cnt_d = r_err_cnt + ERR_W'(1);
          if (r_idx == 2'd3) begin
            w_frm_bad_d = 1'b0;
            if (r_frm_bad || !w_match) begin
              if (r_bad + CNT_W'(1) == LossCnt) begin
                w_state_d = StHunt;
                w_idx_d   = 2'd0;
                w_good_d  = '0;
                w_bad_d   = '0;
              end else begin
                w_bad_d = r_bad + CNT_W'(1);
              end
            end else begin
              w_frame_cnt_d = r_frame_cnt + FRM_W'(1);
              w_bad_d       = '0;
            end
          end else begin
            w_frm_bad_d = r_frm_bad | ~w_match;
          end
        end
        default: w_state_d = StHunt;
      endcase
    end

    // Clear beats any same-cycle increment.
    if (clr_cnt) begin
      w_frame_cnt_d = '0;
      w_err_cnt_d   = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= StHunt;
      r_idx       <= 2'd0;
      r_good      <= '0;
      r_bad       <= '0;
      r_frm_bad   <= 1'b0;
      r_comma     <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_good      <= w_good_d;
      r_bad       <= w_bad_d;
      r_frm_bad   <= w_frm_bad_d;
      r_comma     <= w_comma_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_err_cnt   <= w_err_cnt_d;
    end
  end

  assign locked     = (r_state == StLocked);
  assign comma_seen = r_comma;
  assign frame_cnt  = r_frame_cnt;
  assign err_cnt    = r_err_cnt;

endmodule
